// File: rtl/stack_unit.sv
// ============================================================================
//  Module   : stack_unit
//  Purpose  : Operand stack with PUSH / POP / POP2 / CLEAR over a valid/ready
//             handshake, sticky overflow and underflow flags.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stack_unit #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_cmd_valid,
    input  logic [1:0]       i_cmd_op,
    output logic             o_cmd_ready,
    input  logic [WIDTH-1:0] i_push_data,
    output logic [WIDTH-1:0] o_a_out,
    output logic [WIDTH-1:0] o_b_out,
    output logic             o_done,
    output logic [CW-1:0]    o_count,
    output logic             o_empty,
    output logic             o_full,
    output logic             o_err_ovf,
    output logic             o_err_udf
);

    localparam logic [1:0]    c_op_push  = 2'b00;
    localparam logic [1:0]    c_op_pop   = 2'b01;
    localparam logic [1:0]    c_op_pop2  = 2'b10;
    localparam logic [1:0]    c_op_clear = 2'b11;
    localparam logic [CW-1:0] c_one      = CW'(1);
    localparam logic [CW-1:0] c_two      = CW'(2);
    localparam logic [CW-1:0] c_full     = CW'(DEPTH);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_POP2_B = 1'b1
    } state_t;

    state_t             r_state;
    logic [CW-1:0]      r_sp;
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_done;
    logic               r_ovf;
    logic               r_udf;

    logic               w_accept;
    logic               w_full;
    logic [CW-1:0]      w_sp_m1;
    logic [WIDTH-1:0]   w_top;

    assign w_accept = i_cmd_valid && (r_state == S_IDLE);
    assign w_full   = (r_sp == c_full);
    assign w_sp_m1  = r_sp - c_one;
    assign w_top    = r_mem[w_sp_m1[CW-2:0]];

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_accept && (i_cmd_op == c_op_push) && !w_full) begin
            r_mem[r_sp[CW-2:0]] <= i_push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_sp    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_done <= 1'b1;
                        case (i_cmd_op)
                            c_op_push: begin
                                if (!w_full) r_sp  <= r_sp + c_one;
                                else         r_ovf <= 1'b1;
                            end
                            c_op_pop: begin
                                if (r_sp != '0) begin
                                    r_a  <= w_top;
                                    r_sp <= w_sp_m1;
                                end else begin
                                    r_udf <= 1'b1;
                                end
                            end
                            c_op_pop2: begin
                                // Second operand is fetched in S_POP2_B; done waits for it.
                                if (r_sp >= c_two) begin
                                    r_a     <= w_top;
                                    r_sp    <= w_sp_m1;
                                    r_done  <= 1'b0;
                                    r_state <= S_POP2_B;
                                end else begin
                                    r_udf <= 1'b1;
                                end
                            end
                            c_op_clear: begin
                                r_sp  <= '0;
                                r_ovf <= 1'b0;
                                r_udf <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                S_POP2_B: begin
                    r_b     <= w_top;
                    r_sp    <= w_sp_m1;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_cmd_ready = (r_state == S_IDLE);
    assign o_a_out     = r_a;
    assign o_b_out     = r_b;
    assign o_done      = r_done;
    assign o_count     = r_sp;
    assign o_empty     = (r_sp == '0);
    assign o_full      = w_full;
    assign o_err_ovf   = r_ovf;
    assign o_err_udf   = r_udf;

endmodule

`default_nettype wire
